mode_sequencer: RTL and testbench

MODE_SEQUENCER -- requirements
Module: mode_sequencer

---
 rtl/types_pkg.sv | 63 ++++++
 rtl/button_debounce.sv | 141 ++++++++++++++
 rtl/mode_sequencer.sv | 78 +++++++
 tb/tb_mode_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// ----------------------------------------------------------------------------
// types_pkg
// Shared types and helpers for the mode sequencer slice.
//   WORD_W        operand word width
//   word_t        operand word type (switch bank / operand snapshot)
//   opr_mode_t    operation mode presented to the downstream operation selector
//   db_state_t    per-button debounce FSM state
//   next_mode_fn  step one mode forward, COUNT_ONES wraps to RESET
//   prev_mode_fn  step one mode backward, RESET wraps to COUNT_ONES
// Both helpers map an illegal encoding to RESET so that a corrupted mode
// register recovers on the next button action in either direction.
// ----------------------------------------------------------------------------
package types_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        RESET        = 3'd0,
        ADD          = 3'd1,
        SUB          = 3'd2,
        MUL          = 3'd3,
        LEADING_ONES = 3'd4,
        COUNT_ONES   = 3'd5
    } opr_mode_t;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } db_state_t;

    function automatic opr_mode_t next_mode_fn(input opr_mode_t mode);
        opr_mode_t result;
        case (mode)
            RESET:        result = ADD;
            ADD:          result = SUB;
            SUB:          result = MUL;
            MUL:          result = LEADING_ONES;
            LEADING_ONES: result = COUNT_ONES;
            COUNT_ONES:   result = RESET;
            default:      result = RESET;
        endcase
        return result;
    endfunction

    function automatic opr_mode_t prev_mode_fn(input opr_mode_t mode);
        opr_mode_t result;
        case (mode)
            RESET:        result = COUNT_ONES;
            ADD:          result = RESET;
            SUB:          result = ADD;
            MUL:          result = SUB;
            LEADING_ONES: result = MUL;
            COUNT_ONES:   result = LEADING_ONES;
            default:      result = RESET;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// ----------------------------------------------------------------------------
// button_debounce
// Turns one raw, asynchronous, active-high push button into a single-cycle
// press strobe.
//
// Configuration macro: MODE_SEQ_DEBOUNCE_EN
//   defined   : 2-flop synchronizer followed by a four-state debounce FSM.
//               A level change is accepted only after DEBOUNCE_CYCLES
//               consecutive identical synchronized samples. The strobe is a
//               registered pulse on the accepted press only; releases and
//               long holds produce nothing further.
//   undefined : 2-flop synchronizer followed by a rising-edge detector on
//               the synchronized level. DEBOUNCE_CYCLES is not used.
//
// Ports
//   clk     rising-edge system clock
//   rst_n   synchronous active-low reset; clears synchronizer, FSM, counter
//   btn     raw button level (asynchronous)
//   strobe  one-cycle press strobe
// ----------------------------------------------------------------------------
module button_debounce
    import types_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic strobe
);

    logic sync_meta;
    logic sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
        end else begin
            sync_meta <= btn;
            sync      <= sync_meta;
        end
    end

`ifdef MODE_SEQ_DEBOUNCE_EN

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    db_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    // Saturating increment. The counter is zero whenever the FSM sits in
    // IDLE or PRESSED, so the sample that leaves those states counts as the
    // first of the required run.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            strobe <= 1'b0;
        end else begin
            strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync) begin
                        if (cnt_inc == CNT_MAX) begin
                            state  <= PRESSED;
                            strobe <= 1'b1;
                            cnt    <= '0;
                        end else begin
                            state <= WAIT_PRESS;
                            cnt   <= cnt_inc;
                        end
                    end
                end
                WAIT_PRESS: begin
                    if (!sync) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt_inc == CNT_MAX) begin
                        state  <= PRESSED;
                        strobe <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                PRESSED: begin
                    if (!sync) begin
                        if (cnt_inc == CNT_MAX) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            state <= WAIT_RELEASE;
                            cnt   <= cnt_inc;
                        end
                    end
                end
                WAIT_RELEASE: begin
                    // A bounce back to 1 during release is still the same
                    // press, so return to PRESSED without a new strobe.
                    if (sync) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt_inc == CNT_MAX) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`else

    logic sync_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_prev <= 1'b0;
        end else begin
            sync_prev <= sync;
        end
    end

    // Because the synchronizer clears on reset, a button held through reset
    // release shows up as a fresh rising edge.
    assign strobe = sync & ~sync_prev;

`endif

endmodule

// File: rtl/mode_sequencer.sv
// ----------------------------------------------------------------------------
// mode_sequencer
// Steps an operation mode forward/backward from two push buttons and
// snapshots the switch operands whenever the mode changes.
//
// Configuration macro: MODE_SEQ_DEBOUNCE_EN (passed through to
// button_debounce; enables the counter-based debounce FSMs, otherwise each
// button uses a plain synchronized rising-edge detector).
//
// Ports
//   CLK100MHZ   rising-edge system clock
//   CPU_RESETN  synchronous active-low reset
//   BTNC        raw "next mode" button, active-high
//   BTNL        raw "previous mode" button, active-high
//   SW          raw switch operands
//   SELECTOR    registered current mode
//   SW_OUT      registered operand snapshot taken with each mode change
//   MODE_CHG    one-cycle pulse in the cycle SELECTOR takes a new value
//
// Mode order: RESET, ADD, SUB, MUL, LEADING_ONES, COUNT_ONES (wrapping).
// Latency: one cycle from strobe to SELECTOR/SW_OUT/MODE_CHG; from a clean
// press edge that is 2 (synchronizer) + DEBOUNCE_CYCLES + 1 cycles.
// ----------------------------------------------------------------------------
module mode_sequencer
    import types_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic      CLK100MHZ,
    input  logic      CPU_RESETN,
    input  logic      BTNC,
    input  logic      BTNL,
    input  word_t     SW,
    output opr_mode_t SELECTOR,
    output word_t     SW_OUT,
    output logic      MODE_CHG
);

    logic next_strobe;
    logic prev_strobe;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_next (
        .clk   (CLK100MHZ),
        .rst_n (CPU_RESETN),
        .btn   (BTNC),
        .strobe(next_strobe)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_prev (
        .clk   (CLK100MHZ),
        .rst_n (CPU_RESETN),
        .btn   (BTNL),
        .strobe(prev_strobe)
    );

    // Simultaneous next and previous strobes cancel: nothing moves, nothing
    // is captured and no change pulse is raised.
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            SELECTOR <= RESET;
            SW_OUT   <= '0;
            MODE_CHG <= 1'b0;
        end else begin
            MODE_CHG <= 1'b0;
            if (next_strobe ^ prev_strobe) begin
                SELECTOR <= next_strobe ? next_mode_fn(SELECTOR)
                                        : prev_mode_fn(SELECTOR);
                SW_OUT   <= SW;
                MODE_CHG <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mode_sequencer.sv
// ----------------------------------------------------------------------------
// tb_mode_sequencer
// Directed bench for mode_sequencer with DEBOUNCE_CYCLES = 4. A cycle-level
// behavioural model (button levels delayed two cycles, debounce expressed as
// "level accepted after D equal samples", modes as integers modulo 6) runs
// beside the DUT and is compared on every cycle; directed scenarios add
// literal expectations. Works with or without MODE_SEQ_DEBOUNCE_EN.
// ----------------------------------------------------------------------------
module tb_mode_sequencer;
    import types_pkg::*;

    localparam int D = 4;
`ifdef MODE_SEQ_DEBOUNCE_EN
    localparam int LAT = 2 + D + 1;
`else
    localparam int LAT = 3;
`endif

    logic      clk;
    logic      rst_n;
    logic      btnc;
    logic      btnl;
    word_t     sw;
    opr_mode_t selector;
    word_t     sw_out;
    logic      mode_chg;

    int checks = 0;
    int errors = 0;

    mode_sequencer #(.DEBOUNCE_CYCLES(D)) dut (
        .CLK100MHZ (clk),
        .CPU_RESETN(rst_n),
        .BTNC      (btnc),
        .BTNL      (btnl),
        .SW        (sw),
        .SELECTOR  (selector),
        .SW_OUT    (sw_out),
        .MODE_CHG  (mode_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit model_on = 0;
    int m_sel, m_sw, m_chg;
    int s1[2], s2[2], sp[2], lvl[2], run[2], strb[2];

    always @(posedge clk) begin
        int sn, sb, b_in[2];
        b_in[0] = int'(btnc);
        b_in[1] = int'(btnl);
        if (!rst_n) begin
            m_sel = 0; m_sw = 0; m_chg = 0;
            for (int b = 0; b < 2; b++) begin
                s1[b] = 0; s2[b] = 0; sp[b] = 0; lvl[b] = 0; run[b] = 0; strb[b] = 0;
            end
            model_on = 1;
        end else begin
`ifdef MODE_SEQ_DEBOUNCE_EN
            sn = strb[0];
            sb = strb[1];
`else
            sn = (s2[0] == 1 && sp[0] == 0) ? 1 : 0;
            sb = (s2[1] == 1 && sp[1] == 0) ? 1 : 0;
`endif
            m_chg = 0;
            if (sn != sb) begin
                m_sel = (sn == 1) ? (m_sel + 1) % 6 : (m_sel + 5) % 6;
                m_sw  = int'(sw);
                m_chg = 1;
            end
            for (int b = 0; b < 2; b++) begin
`ifdef MODE_SEQ_DEBOUNCE_EN
                strb[b] = 0;
                if (s2[b] != lvl[b]) run[b]++;
                else run[b] = 0;
                if (run[b] == D) begin
                    lvl[b]  = s2[b];
                    run[b]  = 0;
                    strb[b] = lvl[b];
                end
`endif
                sp[b] = s2[b];
                s2[b] = s1[b];
                s1[b] = b_in[b];
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_on) begin
            checks++;
            if (int'(selector) != m_sel || int'(sw_out) != m_sw || int'(mode_chg) != m_chg) begin
                errors++;
                $display("FAIL model_cmp t=%0t actual sel=%0d sw=%h chg=%0d required sel=%0d sw=%h chg=%0d",
                         $time, selector, sw_out, mode_chg, m_sel, m_sw[15:0], m_chg);
            end
        end
    end

    // ---------------- directed helpers ----------------
    int cyc_no, chg_cnt, first_chg;

    task automatic cyc();
        @(negedge clk);
        cyc_no++;
        if (mode_chg) begin
            chg_cnt++;
            if (first_chg < 0) first_chg = cyc_no;
        end
    endtask

    task automatic run_n(input int n);
        repeat (n) cyc();
    endtask

    task automatic arm();
        cyc_no = 0;
        chg_cnt = 0;
        first_chg = -1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    int exp_seq[6] = '{1, 2, 3, 4, 5, 0};

    initial begin
        rst_n = 1'b0; btnc = 1'b0; btnl = 1'b0; sw = '0;
        arm();
        run_n(3);
        check("reset_sel", int'(selector), 0);
        check("reset_sw", int'(sw_out), 0);
        check("reset_chg", int'(mode_chg), 0);
        rst_n = 1'b1;
        run_n(2);

        // Held press: one change, snapshot of SW
        sw = 16'h00A5;
        arm(); btnc = 1'b1;
        run_n(20);
        check("hold_pulses", chg_cnt, 1);
        check("hold_latency", first_chg, LAT);
        check("hold_sel", int'(selector), 1);
        check("hold_sw", int'(sw_out), 16'h00A5);
        btnc = 1'b0; sw = 16'h1234;
        run_n(12);
        check("release_no_chg", chg_cnt, 1);
        check("sw_out_holds", int'(sw_out), 16'h00A5);

        // Glitch 1-0-1-0
        arm();
        btnc = 1'b1; cyc(); btnc = 1'b0; cyc();
        btnc = 1'b1; cyc(); btnc = 1'b0;
        run_n(12);
`ifdef MODE_SEQ_DEBOUNCE_EN
        check("glitch_pulses", chg_cnt, 0);
        check("glitch_sel", int'(selector), 1);
`else
        check("glitch_pulses", chg_cnt, 2);
        check("glitch_sel", int'(selector), 3);
`endif

        // Six clean presses from RESET
        rst_n = 1'b0; run_n(2); rst_n = 1'b1; run_n(2);
        check("rst2_sel", int'(selector), 0);
        arm();
        for (int i = 0; i < 6; i++) begin
            sw = word_t'(16'h0100 + i);
            btnc = 1'b1; run_n(8);
            btnc = 1'b0; run_n(10);
            check($sformatf("seq_sel_%0d", i), int'(selector), exp_seq[i]);
            check($sformatf("seq_sw_%0d", i), int'(sw_out), 16'h0100 + i);
        end
        check("seq_pulses", chg_cnt, 6);

        // Previous from RESET wraps to COUNT_ONES
        arm(); btnl = 1'b1; run_n(10); btnl = 1'b0; run_n(10);
        check("prev_wrap_sel", int'(selector), 5);
        check("prev_wrap_pulses", chg_cnt, 1);

        // Both buttons together
        arm(); btnc = 1'b1; btnl = 1'b1; run_n(20);
        btnc = 1'b0; btnl = 1'b0; run_n(12);
        check("both_pulses", chg_cnt, 0);
        check("both_sel", int'(selector), 5);

        // Reset aborts a press in progress
        arm(); btnc = 1'b1; run_n(5);
        rst_n = 1'b0; btnc = 1'b0; run_n(2);
        rst_n = 1'b1; run_n(12);
        check("abort_sel", int'(selector), 0);
`ifdef MODE_SEQ_DEBOUNCE_EN
        check("abort_pulses", chg_cnt, 0);
`else
        check("abort_pulses", chg_cnt, 1);
`endif

        // Button held through reset release is a new press
        btnc = 1'b1; run_n(3);
        rst_n = 1'b0; run_n(2);
        rst_n = 1'b1;
        arm(); run_n(15);
        check("held_rst_pulses", chg_cnt, 1);
        check("held_rst_latency", first_chg, LAT);
        check("held_rst_sel", int'(selector), 1);
        btnc = 1'b0; run_n(12);

        // Single-cycle press
        arm(); btnc = 1'b1; cyc(); btnc = 1'b0; run_n(10);
`ifdef MODE_SEQ_DEBOUNCE_EN
        check("short_pulses", chg_cnt, 0);
        check("short_sel", int'(selector), 1);
`else
        check("short_pulses", chg_cnt, 1);
        check("short_latency", first_chg, 3);
        check("short_sel", int'(selector), 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
